// File: rtl/parking_pkg.sv
// Shared types and width helpers for the parking lot controller.
package parking_pkg;

  // Controller states; encodings are fixed so they can be decoded externally.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DOOR_ENTRY = 2'd1,
    DOOR_EXIT  = 2'd2
  } state_t;

  // Width of a slot index for n slots (at least 1 bit).
  function automatic int unsigned slot_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a down-counter that must hold h-1 (at least 1 bit).
  function automatic int unsigned hold_cnt_w(input int unsigned h);
    return (h <= 2) ? 1 : $clog2(h);
  endfunction

endpackage

// File: rtl/parking_slot_finder.sv
// Occupancy to free-slot count and lowest-index free slot (pure combinational).
module parking_slot_finder
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned SLOT_W    = slot_idx_w(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] occupancy,
  output logic [SLOT_W:0]      capacity,
  output logic [SLOT_W-1:0]    best_slot
);

  // Popcount of free slots; scanning downward leaves the lowest free index in best_slot.
  always_comb begin
    capacity  = '0;
    best_slot = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        capacity  = capacity + (SLOT_W + 1)'(1);
        best_slot = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/parking_lot_ctrl.sv
// N-slot parking controller: occupancy tracking, lowest-free-slot assignment,
// timed door hold, full-lot and invalid-exit pulses.
// Optional feature macro: PARKING_STATS_EN adds saturating event counters.
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS        = 8,
  parameter int unsigned SLOT_W           = slot_idx_w(NUM_SLOTS),
  parameter int unsigned DOOR_HOLD_CYCLES = 4,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_sensor,
  input  logic                 exit_sensor,
  input  logic [SLOT_W-1:0]    exit_location,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [SLOT_W:0]      capacity,
  output logic [SLOT_W-1:0]    best_slot,
  output logic                 door_open,
  output logic                 full_light,
  output logic                 exit_err,
  output logic                 busy
`ifdef PARKING_STATS_EN
  ,
  output logic [CNT_W-1:0]     stat_entries,
  output logic [CNT_W-1:0]     stat_exits,
  output logic [CNT_W-1:0]     stat_rejects
`endif
);

  localparam int unsigned HOLD_W = hold_cnt_w(DOOR_HOLD_CYCLES);
  localparam int unsigned PAD_W  = 1 << SLOT_W;

  // Reject nonsensical configurations at elaboration.
  if (NUM_SLOTS < 2 || NUM_SLOTS > 64 || DOOR_HOLD_CYCLES < 1 || CNT_W < 1) begin : g_param_err
    $error("parking_lot_ctrl: parameter out of range");
  end

  state_t                 state;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   entry_pending;
  logic [PAD_W-1:0]       occ_pad;
  logic [NUM_SLOTS-1:0]   entry_mask;
  logic [NUM_SLOTS-1:0]   exit_mask;
  logic                   entry_req;
  logic                   acc_entry;
  logic                   acc_exit;
  logic                   rej_entry;
  logic                   rej_exit;

  parking_slot_finder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_finder (
    .occupancy (occupancy),
    .capacity  (capacity),
    .best_slot (best_slot)
  );

  // Zero-padded view so out-of-range exit locations read as empty slots.
  assign occ_pad    = PAD_W'(occupancy);
  assign entry_mask = NUM_SLOTS'(1) << best_slot;
  assign exit_mask  = NUM_SLOTS'(1) << exit_location;
  // An entry deferred by a winning exit stays requested until served.
  assign entry_req  = entry_sensor | entry_pending;

  // Decode the request sampled this cycle; exit has priority over entry.
  always_comb begin
    acc_entry = 1'b0;
    acc_exit  = 1'b0;
    rej_entry = 1'b0;
    rej_exit  = 1'b0;
    if (state == IDLE) begin
      if (exit_sensor) begin
        acc_exit = occ_pad[exit_location];
        rej_exit = ~occ_pad[exit_location];
      end else if (entry_req) begin
        acc_entry = (capacity != '0);
        rej_entry = (capacity == '0);
      end
    end
  end

  // Controller FSM with occupancy register, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      entry_pending <= 1'b0;
      occupancy     <= '0;
      door_open     <= 1'b0;
      full_light    <= 1'b0;
      exit_err      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      full_light <= rej_entry;
      exit_err   <= rej_exit;
      unique case (state)
        IDLE: begin
          if (exit_sensor) begin
            entry_pending <= entry_req;
          end else if (entry_req) begin
            entry_pending <= 1'b0;
          end
          if (acc_exit) begin
            occupancy <= occupancy & ~exit_mask;
            door_open <= 1'b1;
            busy      <= 1'b1;
            hold_cnt  <= HOLD_W'(DOOR_HOLD_CYCLES - 1);
            state     <= DOOR_EXIT;
          end else if (acc_entry) begin
            occupancy <= occupancy | entry_mask;
            door_open <= 1'b1;
            busy      <= 1'b1;
            hold_cnt  <= HOLD_W'(DOOR_HOLD_CYCLES - 1);
            state     <= DOOR_ENTRY;
          end
        end
        DOOR_ENTRY, DOOR_EXIT: begin
          if (hold_cnt == '0) begin
            door_open <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          door_open <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef PARKING_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_entries <= '0;
      stat_exits   <= '0;
      stat_rejects <= '0;
    end else begin
      if (acc_entry && stat_entries != '1) stat_entries <= stat_entries + CNT_W'(1);
      if (acc_exit && stat_exits != '1) stat_exits <= stat_exits + CNT_W'(1);
      if ((rej_entry || rej_exit) && stat_rejects != '1) begin
        stat_rejects <= stat_rejects + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed self-checking bench for parking_lot_ctrl (8-slot and 6-slot instances).
module tb_parking_lot_ctrl;

  logic       clk = 1'b0;
  logic       reset, entry_sensor, exit_sensor;
  logic [2:0] exit_location;
  logic [7:0] occupancy;
  logic [3:0] capacity;
  logic [2:0] best_slot;
  logic       door_open, full_light, exit_err, busy;

  logic       reset2, entry2, exit2;
  logic [2:0] loc2;
  logic [5:0] occ2;
  logic [3:0] cap2;
  logic [2:0] best2;
  logic       door2, full2, err2, busy2;

`ifdef PARKING_STATS_EN
  logic [15:0] stat_entries, stat_exits, stat_rejects;
  logic [15:0] stat_entries2, stat_exits2, stat_rejects2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parking_lot_ctrl #(
    .NUM_SLOTS        (8),
    .DOOR_HOLD_CYCLES (4),
    .CNT_W            (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .entry_sensor  (entry_sensor),
    .exit_sensor   (exit_sensor),
    .exit_location (exit_location),
    .occupancy     (occupancy),
    .capacity      (capacity),
    .best_slot     (best_slot),
    .door_open     (door_open),
    .full_light    (full_light),
    .exit_err      (exit_err),
    .busy          (busy)
`ifdef PARKING_STATS_EN
    ,
    .stat_entries  (stat_entries),
    .stat_exits    (stat_exits),
    .stat_rejects  (stat_rejects)
`endif
  );

  parking_lot_ctrl #(
    .NUM_SLOTS        (6),
    .DOOR_HOLD_CYCLES (4),
    .CNT_W            (16)
  ) dut6 (
    .clk           (clk),
    .reset         (reset2),
    .entry_sensor  (entry2),
    .exit_sensor   (exit2),
    .exit_location (loc2),
    .occupancy     (occ2),
    .capacity      (cap2),
    .best_slot     (best2),
    .door_open     (door2),
    .full_light    (full2),
    .exit_err      (err2),
    .busy          (busy2)
`ifdef PARKING_STATS_EN
    ,
    .stat_entries  (stat_entries2),
    .stat_exits    (stat_exits2),
    .stat_rejects  (stat_rejects2)
`endif
  );

  // Advance one clock and settle just past the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    checks++; if (occupancy !== 8'h00) begin errors++; $display("FAIL reset_occ got %h want 00", occupancy); end
    checks++; if (capacity !== 4'd8) begin errors++; $display("FAIL reset_cap got %0d want 8", capacity); end
    checks++; if (best_slot !== 3'd0) begin errors++; $display("FAIL reset_best got %0d want 0", best_slot); end
    checks++;
    if ({door_open, full_light, exit_err, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {door_open, full_light, exit_err, busy});
    end
  endtask

  task automatic test_fill;
    logic [7:0] exp_occ;
    int         n_open;
    for (int k = 0; k < 8; k++) begin
      exp_occ = 8'((16'd1 << (k + 1)) - 16'd1);
      checks++; if (best_slot !== 3'(k)) begin errors++; $display("FAIL fill_best k=%0d got %0d want %0d", k, best_slot, k); end
      checks++; if (capacity !== 4'(8 - k)) begin errors++; $display("FAIL fill_cap k=%0d got %0d want %0d", k, capacity, 8 - k); end
      entry_sensor = 1'b1;
      tick();
      entry_sensor = 1'b0;
      checks++; if (occupancy !== exp_occ) begin errors++; $display("FAIL fill_occ k=%0d got %h want %h", k, occupancy, exp_occ); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy k=%0d got %b want 1", k, busy); end
      n_open = (door_open === 1'b1) ? 1 : 0;
      for (int j = 0; j < 5; j++) begin
        tick();
        if (door_open === 1'b1) n_open++;
      end
      checks++; if (n_open != 4) begin errors++; $display("FAIL fill_door_cycles k=%0d got %0d want 4", k, n_open); end
    end
    checks++; if (capacity !== 4'd0) begin errors++; $display("FAIL fill_cap_end got %0d want 0", capacity); end
  endtask

  task automatic test_full;
    entry_sensor = 1'b1;
    tick();
    entry_sensor = 1'b0;
    checks++; if (full_light !== 1'b1) begin errors++; $display("FAIL full_light got %b want 1", full_light); end
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL full_door got %b want 0", door_open); end
    checks++; if (occupancy !== 8'hFF) begin errors++; $display("FAIL full_occ got %h want FF", occupancy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy got %b want 0", busy); end
    tick();
    checks++; if (full_light !== 1'b0) begin errors++; $display("FAIL full_pulse_len got %b want 0", full_light); end
  endtask

  task automatic test_exit_reenter;
    exit_sensor   = 1'b1;
    exit_location = 3'd3;
    tick();
    exit_sensor = 1'b0;
    checks++; if (occupancy !== 8'hF7) begin errors++; $display("FAIL exit_occ got %h want F7", occupancy); end
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL exit_door got %b want 1", door_open); end
    tick(4);
    checks++; if ({door_open, busy} !== 2'b00) begin errors++; $display("FAIL exit_close got %b want 00", {door_open, busy}); end
    checks++; if (best_slot !== 3'd3) begin errors++; $display("FAIL exit_best got %0d want 3", best_slot); end
    checks++; if (capacity !== 4'd1) begin errors++; $display("FAIL exit_cap got %0d want 1", capacity); end
    entry_sensor = 1'b1;
    tick();
    entry_sensor = 1'b0;
    checks++; if (occupancy !== 8'hFF) begin errors++; $display("FAIL reenter_occ got %h want FF", occupancy); end
    tick(4);
`ifdef PARKING_STATS_EN
    checks++; if (stat_entries !== 16'd9) begin errors++; $display("FAIL stat_entries got %0d want 9", stat_entries); end
    checks++; if (stat_exits !== 16'd1) begin errors++; $display("FAIL stat_exits got %0d want 1", stat_exits); end
    checks++; if (stat_rejects !== 16'd1) begin errors++; $display("FAIL stat_rejects got %0d want 1", stat_rejects); end
`endif
  endtask

  task automatic test_invalid_exit;
    for (int s = 7; s >= 4; s--) begin
      exit_sensor   = 1'b1;
      exit_location = 3'(s);
      tick();
      exit_sensor = 1'b0;
      tick(4);
    end
    checks++; if (occupancy !== 8'h0F) begin errors++; $display("FAIL drain_occ got %h want 0F", occupancy); end
    exit_sensor   = 1'b1;
    exit_location = 3'd5;
    tick();
    exit_sensor = 1'b0;
    checks++; if (exit_err !== 1'b1) begin errors++; $display("FAIL empty_exit_err got %b want 1", exit_err); end
    checks++; if (occupancy !== 8'h0F) begin errors++; $display("FAIL empty_exit_occ got %h want 0F", occupancy); end
    checks++; if ({door_open, busy} !== 2'b00) begin errors++; $display("FAIL empty_exit_door got %b want 00", {door_open, busy}); end
    tick();
    checks++; if (exit_err !== 1'b0) begin errors++; $display("FAIL empty_exit_pulse got %b want 0", exit_err); end

    // Six-slot lot: fill it, then exit an index beyond the last slot.
    reset2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      entry2 = 1'b1;
      tick();
      entry2 = 1'b0;
      tick(4);
    end
    checks++; if (occ2 !== 6'h3F) begin errors++; $display("FAIL six_fill_occ got %h want 3F", occ2); end
    checks++; if (cap2 !== 4'd0) begin errors++; $display("FAIL six_fill_cap got %0d want 0", cap2); end
    exit2 = 1'b1;
    loc2  = 3'd7;
    tick();
    exit2 = 1'b0;
    checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL six_range_err got %b want 1", err2); end
    checks++; if (occ2 !== 6'h3F) begin errors++; $display("FAIL six_range_occ got %h want 3F", occ2); end
    checks++; if (door2 !== 1'b0) begin errors++; $display("FAIL six_range_door got %b want 0", door2); end
  endtask

  task automatic test_simultaneous;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    entry_sensor = 1'b1;
    tick();
    entry_sensor = 1'b0;
    tick(4);
    checks++; if (occupancy !== 8'h01) begin errors++; $display("FAIL simul_setup got %h want 01", occupancy); end
    entry_sensor  = 1'b1;
    exit_sensor   = 1'b1;
    exit_location = 3'd0;
    tick();
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    checks++; if (occupancy !== 8'h00) begin errors++; $display("FAIL simul_exit_first got %h want 00", occupancy); end
    checks++; if ({door_open, busy} !== 2'b11) begin errors++; $display("FAIL simul_door got %b want 11", {door_open, busy}); end
    tick(3);
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL simul_hold got %b want 1", door_open); end
    tick();
    checks++; if ({door_open, busy} !== 2'b00) begin errors++; $display("FAIL simul_close got %b want 00", {door_open, busy}); end
    checks++; if (occupancy !== 8'h00) begin errors++; $display("FAIL simul_wait_occ got %h want 00", occupancy); end
    tick();
    checks++; if (occupancy !== 8'h01) begin errors++; $display("FAIL simul_entry_served got %h want 01", occupancy); end
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL simul_entry_door got %b want 1", door_open); end
    tick(4);
  endtask

  task automatic test_reset_mid_hold;
    entry_sensor = 1'b1;
    tick();
    entry_sensor = 1'b0;
    checks++; if (occupancy !== 8'h03) begin errors++; $display("FAIL midhold_occ got %h want 03", occupancy); end
    tick(2);
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL midhold_open got %b want 1", door_open); end
    reset = 1'b1;
    tick();
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL midhold_door got %b want 0", door_open); end
    checks++; if (occupancy !== 8'h00) begin errors++; $display("FAIL midhold_occ_clr got %h want 00", occupancy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midhold_busy got %b want 0", busy); end
    checks++; if (capacity !== 4'd8) begin errors++; $display("FAIL midhold_cap got %0d want 8", capacity); end
`ifdef PARKING_STATS_EN
    checks++;
    if ({stat_entries, stat_exits, stat_rejects} !== 48'd0) begin
      errors++; $display("FAIL midhold_stats got %0d/%0d/%0d want 0/0/0", stat_entries, stat_exits, stat_rejects);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    entry_sensor  = 1'b0;
    exit_sensor   = 1'b0;
    exit_location = 3'd0;
    reset2        = 1'b1;
    entry2        = 1'b0;
    exit2         = 1'b0;
    loc2          = 3'd0;
    test_reset();
    test_fill();
    test_full();
    test_exit_reenter();
    test_invalid_exit();
    test_simultaneous();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
